// File: rtl/msg_read_sched.sv
// Message read scheduler: fetches start/end pairs from the location store and offers them downstream.
// Latency: 4 cycles from pending != 0 in IDLE to msg_valid_o; backpressure holds OFFER until msg_ready_i.
// Optional MSG_READ_SCHED_OVF_EN adds a sticky ovf_o flagging stores dropped while full.
module msg_read_sched #(
    parameter int NUM_MESSAGE = 10,
    parameter int DATA_WIDTH  = 5,
    parameter int PTR_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  store_end_i,
    input  logic [DATA_WIDTH-1:0] mem_start_i,
    input  logic [DATA_WIDTH-1:0] mem_end_i,
    output logic                  re_o,
    output logic                  read_start_o,
    output logic                  read_end_o,
    output logic [PTR_WIDTH-1:0]  addr_o,
    output logic                  msg_valid_o,
    input  logic                  msg_ready_i,
    output logic [DATA_WIDTH-1:0] msg_start_o,
    output logic [DATA_WIDTH-1:0] msg_end_o,
    output logic [PTR_WIDTH:0]    pending_o,
    output logic                  full_o,
    output logic                  empty_o
`ifdef MSG_READ_SCHED_OVF_EN
    ,
    output logic                  ovf_o
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_S  = 3'd1;
    localparam logic [2:0] RD_E  = 3'd2;
    localparam logic [2:0] CAP   = 3'd3;
    localparam logic [2:0] OFFER = 3'd4;

    localparam logic [PTR_WIDTH-1:0] LAST_SLOT = PTR_WIDTH'(NUM_MESSAGE - 1);
    localparam logic [PTR_WIDTH:0]   FULL_CNT  = (PTR_WIDTH+1)'(NUM_MESSAGE);

    logic [2:0]            r_state;
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [PTR_WIDTH:0]    r_pending;
    logic [DATA_WIDTH-1:0] r_start;
    logic [DATA_WIDTH-1:0] r_end;

    logic w_full;
    logic w_hs;
    logic w_store_acc;

    assign w_full      = (r_pending == FULL_CNT);
    assign w_hs        = (r_state == OFFER) && msg_ready_i;
    // A store while full is still taken if a slot frees in the same cycle.
    assign w_store_acc = store_end_i && (!w_full || w_hs);

    assign re_o         = (r_state == RD_S) || (r_state == RD_E);
    assign read_start_o = (r_state == RD_S);
    assign read_end_o   = (r_state == RD_E);
    assign addr_o       = r_rd_ptr;
    assign msg_valid_o  = (r_state == OFFER);
    assign msg_start_o  = r_start;
    assign msg_end_o    = r_end;
    assign pending_o    = r_pending;
    assign full_o       = w_full;
    assign empty_o      = (r_pending == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pending <= '0;
        end else begin
            if (w_store_acc) begin
                r_wr_ptr <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_hs) begin
                r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_store_acc && !w_hs) begin
                r_pending <= r_pending + 1'b1;
            end else if (w_hs && !w_store_acc) begin
                r_pending <= r_pending - 1'b1;
            end
        end
    end

    // Store read data returns one cycle after re_o, so each field is captured in the following state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_start <= '0;
            r_end   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_pending != '0) begin
                        r_state <= RD_S;
                    end
                end
                RD_S: r_state <= RD_E;
                RD_E: begin
                    r_start <= mem_start_i;
                    r_state <= CAP;
                end
                CAP: begin
                    r_end   <= mem_end_i;
                    r_state <= OFFER;
                end
                OFFER: begin
                    if (msg_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MSG_READ_SCHED_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (store_end_i && !w_store_acc) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf_o = r_ovf;
`endif

endmodule

// File: tb/tb_msg_read_sched.sv
// Scoreboard bench for msg_read_sched: models the location store and the pending queue.
module tb_msg_read_sched;

    localparam int NUM = 10;

    typedef struct packed {
        logic [4:0] s;
        logic [4:0] e;
    } desc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       store_end_i = 1'b0;
    logic [4:0] mem_start_i = '0;
    logic [4:0] mem_end_i = '0;
    logic       re_o, read_start_o, read_end_o;
    logic [3:0] addr_o;
    logic       msg_valid_o;
    logic       msg_ready_i = 1'b0;
    logic [4:0] msg_start_o, msg_end_o;
    logic [4:0] pending_o;
    logic       full_o, empty_o;
`ifdef MSG_READ_SCHED_OVF_EN
    logic       ovf_o;
`endif

    msg_read_sched #(.NUM_MESSAGE(NUM), .DATA_WIDTH(5), .PTR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .store_end_i(store_end_i),
        .mem_start_i(mem_start_i), .mem_end_i(mem_end_i),
        .re_o(re_o), .read_start_o(read_start_o), .read_end_o(read_end_o),
        .addr_o(addr_o), .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i),
        .msg_start_o(msg_start_o), .msg_end_o(msg_end_o),
        .pending_o(pending_o), .full_o(full_o), .empty_o(empty_o)
`ifdef MSG_READ_SCHED_OVF_EN
        , .ovf_o(ovf_o)
`endif
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    desc_t sb[$];
    logic [4:0] mem_s [NUM];
    logic [4:0] mem_e [NUM];
    logic [4:0] nxt_s = '0, nxt_e = '0;
    int    m_wr = 0, m_rd = 0;
    logic  m_ovf = 1'b0;
    int    re_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Location store with one-cycle read latency.
    always @(posedge clk) begin
        if (re_o && read_start_o) mem_start_i <= mem_s[addr_o];
        if (re_o && read_end_o)   mem_end_i   <= mem_e[addr_o];
    end

    // Monitor: checks current outputs, then applies the edge about to happen to the model.
    always @(negedge clk) begin
        logic hs, acc;
        if (!rst) begin
            sb.delete();
            m_wr = 0; m_rd = 0; m_ovf = 1'b0;
        end else begin
            chk("pending", pending_o, sb.size());
            chk("full", full_o, sb.size() == NUM);
            chk("empty", empty_o, sb.size() == 0);
            chk("rd_excl", read_start_o & read_end_o, 0);
            if (re_o) begin
                chk("rd_addr", addr_o, m_rd);
                re_cnt++;
            end
`ifdef MSG_READ_SCHED_OVF_EN
            chk("ovf", ovf_o, m_ovf);
`endif
            if (msg_valid_o) begin
                if (sb.size() == 0) chk("spurious_vld", 1, 0);
                else begin
                    chk("msg_start", msg_start_o, sb[0].s);
                    chk("msg_end", msg_end_o, sb[0].e);
                end
            end
            hs  = msg_valid_o && msg_ready_i && (sb.size() > 0);
            acc = store_end_i && ((sb.size() < NUM) || hs);
            if (hs) begin
                void'(sb.pop_front());
                m_rd = (m_rd + 1) % NUM;
            end
            if (store_end_i && !acc) m_ovf = 1'b1;
            if (acc) begin
                mem_s[m_wr] = nxt_s;
                mem_e[m_wr] = nxt_e;
                sb.push_back('{s: nxt_s, e: nxt_e});
                m_wr = (m_wr + 1) % NUM;
            end
        end
    end

    task automatic store(input logic [4:0] s, input logic [4:0] e);
        @(posedge clk); #1;
        nxt_s = s; nxt_e = e; store_end_i = 1'b1;
        @(posedge clk); #1;
        store_end_i = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        for (int k = 0; k < 50 && !msg_valid_o; k++) @(negedge clk);
        chk(tag, msg_valid_o, 1);
    endtask

    task automatic wait_empty(input string tag);
        for (int k = 0; k < 300 && !(empty_o && sb.size() == 0 && !msg_valid_o); k++) @(negedge clk);
        chk(tag, empty_o && sb.size() == 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk); @(negedge clk); #2;
        rst = 1'b1;
    endtask

    initial begin
        int k, vcnt, re_snap;
        #1;
        chk("rst_empty", empty_o, 1);
        chk("rst_vld", msg_valid_o, 0);
        chk("rst_re", re_o, 0);
        chk("rst_pend", pending_o, 0);
        #21 rst = 1'b1;

        // Single message with latency and read order.
        msg_ready_i = 1'b1;
        store(5'd3, 5'd9);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (msg_valid_o) break;
            if (k == 1) chk("rd_start_sel", read_start_o, 1);
            if (k == 2) chk("rd_end_sel", read_end_o, 1);
            k++;
        end
        chk("latency", k, 4);
        chk("single_start", msg_start_o, 3);
        chk("single_end", msg_end_o, 9);
        @(negedge clk);
        chk("single_vld_once", msg_valid_o, 0);
        wait_empty("single_drain");

        // Backpressure during OFFER.
        msg_ready_i = 1'b0;
        store(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        wait_vld("bp_vld_seen");
        re_snap = re_cnt;
        vcnt = 0;
        repeat (5) begin
            @(negedge clk);
            vcnt += int'(msg_valid_o);
        end
        chk("bp_vld_held", vcnt, 5);
        chk("bp_no_re", re_cnt, re_snap);
        chk("bp_addr", addr_o, 1);
        @(posedge clk); #1 msg_ready_i = 1'b1;
        wait_empty("bp_drain");

        // Fill, overflow, drain and wrap from a fresh reset.
        do_reset();
        msg_ready_i = 1'b0;
        for (int i = 0; i < NUM; i++) store(5'(i + 7), 5'(31 - i));
        @(negedge clk);
        chk("fill_full", full_o, 1);
        chk("fill_pend", pending_o, 10);
        store(5'd1, 5'd2);
        @(negedge clk);
        chk("ovf_pend", pending_o, 10);
`ifdef MSG_READ_SCHED_OVF_EN
        chk("ovf_flag", ovf_o, 1);
`endif
        @(posedge clk); #1 msg_ready_i = 1'b1;
        wait_empty("fill_drain");
        store(5'd17, 5'd4);
        wait_vld("wrap_vld");
        chk("wrap_addr", addr_o, 0);
        wait_empty("wrap_drain");

        // Simultaneous store and handshake at pending 4.
        msg_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) store(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        wait_vld("simul_vld");
        chk("simul_pre", pending_o, 4);
        @(posedge clk); #1;
        nxt_s = 5'd21; nxt_e = 5'd22;
        msg_ready_i = 1'b1; store_end_i = 1'b1;
        @(posedge clk); #1;
        msg_ready_i = 1'b0; store_end_i = 1'b0;
        @(negedge clk);
        chk("simul_pend", pending_o, 4);
        chk("simul_rd", addr_o, 2);
        msg_ready_i = 1'b1;
        wait_empty("simul_drain");

        // Reset while reading the end field.
        store(5'd11, 5'd12);
        for (k = 0; k < 20 && !read_end_o; k++) @(negedge clk);
        chk("rst_rde_seen", read_end_o, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_re", re_o, 0);
        chk("mid_rst_rde", read_end_o, 0);
        chk("mid_rst_vld", msg_valid_o, 0);
        chk("mid_rst_data", {msg_start_o, msg_end_o}, 0);
        chk("mid_rst_pend", pending_o, 0);
        chk("mid_rst_empty", empty_o, 1);
        @(negedge clk); @(negedge clk); #2 rst = 1'b1;
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            vcnt += int'(msg_valid_o);
        end
        chk("no_reoffer", vcnt, 0);
        store(5'd25, 5'd26);
        wait_vld("post_rst_vld");
        chk("post_rst_addr", addr_o, 0);
        wait_empty("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/msg_read_sched.md
MSG_READ_SCHED -- requirements
Module: msg_read_sched

Interface
REQ-001 SHALL have parameter NUM_MESSAGE, default 10, number of message-location slots in the location store.
REQ-002 SHALL have parameter DATA_WIDTH, default 5, width of a start or end buffer address.
REQ-003 SHALL have parameter PTR_WIDTH, default 4, slot-pointer width, with 2**PTR_WIDTH >= NUM_MESSAGE.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port store_end_i, input, 1 bit: one-cycle pulse meaning a message's start/end pair has been written to the location store.
REQ-007 SHALL have port mem_start_i, input, DATA_WIDTH: start address read back from the location store.
REQ-008 SHALL have port mem_end_i, input, DATA_WIDTH: end address read back from the location store.
REQ-009 SHALL have port re_o, output, 1 bit: read enable to the location store.
REQ-010 SHALL have port read_start_o, output, 1 bit: selects the start field for the current read.
REQ-011 SHALL have port read_end_o, output, 1 bit: selects the end field for the current read.
REQ-012 SHALL have port addr_o, output, PTR_WIDTH: slot address for the current read.
REQ-013 SHALL have port msg_valid_o, output, 1 bit: a message descriptor is offered downstream.
REQ-014 SHALL have port msg_ready_i, input, 1 bit: downstream accepts the descriptor.
REQ-015 SHALL have port msg_start_o, output, DATA_WIDTH: start address of the offered message.
REQ-016 SHALL have port msg_end_o, output, DATA_WIDTH: end address of the offered message.
REQ-017 SHALL have port pending_o, output, PTR_WIDTH+1: number of stored messages not yet accepted downstream.
REQ-018 SHALL have port full_o, output, 1 bit: pending_o == NUM_MESSAGE.
REQ-019 SHALL have port empty_o, output, 1 bit: pending_o == 0.

Function
REQ-020 SHALL use a wr_ptr that increments, wrapping NUM_MESSAGE-1 -> 0, on each accepted store_end_i pulse (store_end_i high and full_o low).
REQ-021 SHALL keep rd_ptr pointing at the oldest unaccepted slot, wrapping NUM_MESSAGE-1 -> 0, and advance it on a handshake (msg_valid_o and msg_ready_i both high).
REQ-022 SHALL update pending as follows: +1 on an accepted store only; -1 on a handshake only; unchanged when both happen in the same cycle.
REQ-023 SHALL ignore store_end_i while full_o is high, leaving wr_ptr and pending unchanged, unless a handshake occurs in that same cycle, in which case the store SHALL be accepted.
REQ-024 SHALL implement a Moore FSM with the states IDLE, RD_S, RD_E, CAP and OFFER.
REQ-025 IDLE SHALL go to RD_S when pending != 0, and stay in IDLE otherwise.
REQ-026 RD_S SHALL drive re_o=1, read_start_o=1, addr_o=rd_ptr, then go to RD_E.
REQ-027 RD_E SHALL drive re_o=1, read_end_o=1, addr_o=rd_ptr, register mem_start_i (one-cycle read latency), then go to CAP.
REQ-028 CAP SHALL register mem_end_i, then go to OFFER.
REQ-029 OFFER SHALL hold msg_valid_o=1 and keep msg_start_o/msg_end_o stable until the handshake, then go to IDLE.
REQ-030 SHALL drive re_o, read_start_o and read_end_o to 0 outside RD_S/RD_E, and drive addr_o = rd_ptr at all times.
REQ-031 SHALL have latency: pending becoming nonzero in IDLE in cycle N -> msg_valid_o high in cycle N+4.
REQ-032 SHALL keep read_start_o and read_end_o mutually exclusive in every cycle.

Reset
REQ-033 SHALL, on rst low, immediately force state=IDLE, wr_ptr=0, rd_ptr=0, pending=0, all data registers 0 and all outputs 0, except empty_o=1.
REQ-034 SHALL, on reset mid-fetch or mid-offer, abandon the in-flight descriptor; it SHALL NOT be re-offered after reset.
REQ-035 SHALL leave reset deassertion synchronized outside this block; the first active edge SHALL see state IDLE.

Configuration
REQ-036 SHALL, with MSG_READ_SCHED_OVF_EN defined, add output ovf_o, 1 bit: sticky high from the cycle after a store_end_i is ignored per REQ-023, cleared only by reset.
REQ-037 SHALL, without MSG_READ_SCHED_OVF_EN, omit port ovf_o and drop ignored stores silently; all other behaviour SHALL be identical.

Verification
REQ-038 Single message: reset, one store_end_i pulse, mem_start_i=3, mem_end_i=9, msg_ready_i=1 -> reads of start then end at addr_o=0, msg_valid_o with msg_start_o=3, msg_end_o=9 for one cycle, then pending_o=0, empty_o=1.
REQ-039 Backpressure: msg_ready_i=0 for 5 cycles during OFFER -> msg_valid_o and data held stable for 5 cycles, rd_ptr unchanged, no extra re_o pulses.
REQ-040 Fill and wrap: 10 stores with msg_ready_i=0 -> full_o=1, pending_o=10; drain all 10 -> addr_o sequence 0..9, next store and read use addr_o=0.
REQ-041 Overflow: 11th store while full -> pending_o stays 10, wr_ptr unchanged, ovf_o=1 next cycle (macro defined only).
REQ-042 Simultaneous store and handshake at pending_o=4 -> pending_o stays 4, both pointers advance.
REQ-043 Reset asserted in RD_E -> all outputs 0 immediately, empty_o=1, no msg_valid_o after release until a new store.
